// File: rtl/updown_mod_counter.sv
// updown_mod_counter: modulo up/down counter with programmable top value,
// count enable, synchronous parallel load and a registered terminal-count pulse.
// Optional build macro: UDC_SATURATE_EN. When defined, the count pins at the
// boundary (0 or MAX) instead of wrapping. The default build wraps.
module updown_mod_counter #(
  parameter int N       = 4,
  parameter int MAX     = 2**N - 1,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         m,
  input  logic         load,
  input  logic [N-1:0] din,
  output logic [N-1:0] counter,
  output logic         tc,
  output logic         zero
);

  localparam logic [N-1:0] MAX_V = N'(MAX);
  localparam logic [N-1:0] RST_V = N'(RST_VAL);

  // An out-of-range parameter set stops elaboration instead of building a
  // counter whose range silently differs from what the instantiator asked for.
  generate
    if (MAX > 2**N - 1 || MAX < 1 || RST_VAL > MAX || RST_VAL < 0) begin : g_bad_params
      $error("updown_mod_counter: illegal parameters N=%0d MAX=%0d RST_VAL=%0d",
             N, MAX, RST_VAL);
    end
  endgenerate

  logic [N-1:0] next_cnt;
  logic         next_tc;

  // Next count and terminal-count decision; priority is load, then enable, then hold.
  always_comb begin
    next_cnt = counter;
    next_tc  = 1'b0;
    if (load) begin
      next_cnt = (din > MAX_V) ? MAX_V : din;
    end else if (en) begin
      if (m) begin
        if (counter >= MAX_V) begin
`ifdef UDC_SATURATE_EN
          next_cnt = MAX_V;
`else
          next_cnt = '0;
`endif
          next_tc  = 1'b1;
        end else begin
          next_cnt = counter + N'(1);
        end
      end else begin
        if (counter == '0) begin
`ifdef UDC_SATURATE_EN
          next_cnt = '0;
`else
          next_cnt = MAX_V;
`endif
          next_tc  = 1'b1;
        end else begin
          next_cnt = counter - N'(1);
        end
      end
    end
  end

  // Count and tc registers; reset takes effect immediately without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= RST_V;
      tc      <= 1'b0;
    end else begin
      counter <= next_cnt;
      tc      <= next_tc;
    end
  end

  // zero follows the registered count with no extra latency.
  assign zero = (counter == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: directed scenarios plus randomized traffic
// against a reference model expressed as modular arithmetic on integers.
// Two instances run side by side: N=3/MAX=5/RST_VAL=0 and N=4/MAX=9/RST_VAL=7.
module tb_updown_mod_counter;

  localparam int N1 = 3, MAX1 = 5, RST1 = 0;
  localparam int N2 = 4, MAX2 = 9, RST2 = 7;

  logic          clk = 1'b0;
  logic          reset, en, m, load;
  logic [N1-1:0] din1;
  logic [N2-1:0] din2;
  logic [N1-1:0] cnt1;
  logic [N2-1:0] cnt2;
  logic          tc1, tc2, zero1, zero2;

  int n_checks = 0;
  int n_fail   = 0;
  int exp1, exp2;
  bit etc1, etc2;

  updown_mod_counter #(.N(N1), .MAX(MAX1), .RST_VAL(RST1)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .m(m), .load(load), .din(din1),
    .counter(cnt1), .tc(tc1), .zero(zero1)
  );

  updown_mod_counter #(.N(N2), .MAX(MAX2), .RST_VAL(RST2)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .m(m), .load(load), .din(din2),
    .counter(cnt2), .tc(tc2), .zero(zero2)
  );

  always #5 clk = ~clk;

  // Reference: one clock of a counter over the range 0..max.
  function automatic void model_step(input int max, inout int c, output bit t,
                                     input bit e, input bit up, input bit ld,
                                     input int d);
    t = 1'b0;
    if (ld) begin
      c = (d > max) ? max : d;
    end else if (e) begin
      if (up) begin
        t = (c == max);
`ifdef UDC_SATURATE_EN
        if (c < max) c = c + 1;
`else
        c = (c + 1) % (max + 1);
`endif
      end else begin
        t = (c == 0);
`ifdef UDC_SATURATE_EN
        if (c > 0) c = c - 1;
`else
        c = (c + max) % (max + 1);
`endif
      end
    end
  endfunction

  task automatic model_reset();
    exp1 = RST1; etc1 = 1'b0;
    exp2 = RST2; etc2 = 1'b0;
  endtask

  // Advance one clock edge and the model together; sample 1 time unit later.
  task automatic tick();
    if (reset) begin
      model_reset();
    end else begin
      model_step(MAX1, exp1, etc1, en, m, load, int'(din1));
      model_step(MAX2, exp2, etc2, en, m, load, int'(din2));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; m = 1'b1; load = 1'b0; din1 = '0; din2 = '0;
    #2;
    model_reset();
    n_checks++;
    if (cnt1 !== 3'd0 || tc1 !== 1'b0 || zero1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state1: counter=%0d tc=%b zero=%b, required 0 0 1", cnt1, tc1, zero1);
    end
    n_checks++;
    if (cnt2 !== 4'd7 || tc2 !== 1'b0 || zero2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state2: counter=%0d tc=%b zero=%b, required 7 0 0", cnt2, tc2, zero2);
    end
    en = 1'b1; load = 1'b1;
    tick();
    n_checks++;
    if (cnt1 !== 3'd0 || cnt2 !== 4'd7) begin
      n_fail++;
      $display("FAIL reset_hold: counter1=%0d counter2=%0d, required 0 7", cnt1, cnt2);
    end
    reset = 1'b0; din1 = 3'd3; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    n_checks++;
    if (cnt1 !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_preload: counter=%0d, required 3", cnt1);
    end
    // Assert reset mid-cycle; the count must drop before any further edge.
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (cnt1 !== 3'd0 || tc1 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: counter=%0d tc=%b, required 0 0", cnt1, tc1);
    end
    reset = 1'b0; en = 1'b1; m = 1'b1;
    tick();
    n_checks++;
    if (cnt1 !== 3'd1) begin
      n_fail++;
      $display("FAIL first_edge_after_reset: counter=%0d, required 1", cnt1);
    end
  endtask

`ifndef UDC_SATURATE_EN
  task automatic test_up_wrap();
    int seq[7] = '{1, 2, 3, 4, 5, 0, 1};
    pulse_reset();
    en = 1'b1; m = 1'b1; load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if (cnt1 !== 3'(seq[i]) || tc1 !== (i == 5) || zero1 !== (seq[i] == 0)) begin
        n_fail++;
        $display("FAIL up_wrap[%0d]: counter=%0d tc=%b zero=%b, required %0d %b %b",
                 i, cnt1, tc1, zero1, seq[i], (i == 5), (seq[i] == 0));
      end
    end
  endtask

  task automatic test_down_wrap();
    int seq[3] = '{0, 5, 4};
    load = 1'b1; din1 = 3'd1;
    tick();
    n_checks++;
    if (cnt1 !== 3'd1 || tc1 !== 1'b0) begin
      n_fail++;
      $display("FAIL down_load: counter=%0d tc=%b, required 1 0", cnt1, tc1);
    end
    load = 1'b0; en = 1'b1; m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (cnt1 !== 3'(seq[i]) || tc1 !== (i == 1)) begin
        n_fail++;
        $display("FAIL down_wrap[%0d]: counter=%0d tc=%b, required %0d %b",
                 i, cnt1, tc1, seq[i], (i == 1));
      end
    end
  endtask

  task automatic test_param_variant();
    int seq[3] = '{8, 9, 0};
    pulse_reset();
    n_checks++;
    if (cnt2 !== 4'd7) begin
      n_fail++;
      $display("FAIL variant_reset: counter=%0d, required 7", cnt2);
    end
    en = 1'b1; m = 1'b1; load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (cnt2 !== 4'(seq[i]) || tc2 !== (i == 2) || zero2 !== (i == 2)) begin
        n_fail++;
        $display("FAIL variant_up[%0d]: counter=%0d tc=%b zero=%b, required %0d %b %b",
                 i, cnt2, tc2, zero2, seq[i], (i == 2), (i == 2));
      end
    end
  endtask
`else
  task automatic test_saturate();
    load = 1'b1; din1 = 3'd4; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (cnt1 !== 3'd5 || tc1 !== (i != 0)) begin
        n_fail++;
        $display("FAIL sat_up[%0d]: counter=%0d tc=%b, required 5 %b", i, cnt1, tc1, (i != 0));
      end
    end
    load = 1'b1; din1 = 3'd1;
    tick();
    load = 1'b0; m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (cnt1 !== 3'd0 || tc1 !== (i != 0)) begin
        n_fail++;
        $display("FAIL sat_down[%0d]: counter=%0d tc=%b, required 0 %b", i, cnt1, tc1, (i != 0));
      end
    end
  endtask
`endif

  task automatic test_load_clamp();
    load = 1'b1; din1 = 3'd3; en = 1'b1; m = 1'b1;
    tick();
    n_checks++;
    if (cnt1 !== 3'd3 || tc1 !== 1'b0) begin
      n_fail++;
      $display("FAIL load_priority: counter=%0d tc=%b, required 3 0", cnt1, tc1);
    end
    din1 = 3'd7;
    tick();
    n_checks++;
    if (cnt1 !== 3'd5) begin
      n_fail++;
      $display("FAIL load_clamp: counter=%0d, required 5", cnt1);
    end
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (cnt1 !== 3'd5 || tc1 !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: counter=%0d tc=%b, required 5 0", i, cnt1, tc1);
      end
    end
  endtask

  task automatic test_reversal();
    load = 1'b1; din1 = 3'd4;
    tick();
    load = 1'b0; en = 1'b1; m = 1'b1;
    tick();
    n_checks++;
    if (cnt1 !== 3'd5 || tc1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reverse_reach_max: counter=%0d tc=%b, required 5 0", cnt1, tc1);
    end
    m = 1'b0;
    tick();
    n_checks++;
    if (cnt1 !== 3'd4 || tc1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reverse_at_max: counter=%0d tc=%b, required 4 0", cnt1, tc1);
    end
    load = 1'b1; din1 = 3'd0;
    tick();
    load = 1'b0; m = 1'b1;
    tick();
    n_checks++;
    if (cnt1 !== 3'd1 || tc1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reverse_at_zero: counter=%0d tc=%b, required 1 0", cnt1, tc1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      m    = $urandom_range(0, 1);
      load = ($urandom_range(0, 9) == 0);
      din1 = N1'($urandom_range(0, 7));
      din2 = N2'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) begin
        pulse_reset();
      end else begin
        tick();
      end
      n_checks++;
      if (cnt1 !== N1'(exp1) || tc1 !== etc1 || zero1 !== (exp1 == 0)) begin
        n_fail++;
        $display("FAIL random1[%0d]: counter=%0d tc=%b zero=%b, required %0d %b %b",
                 i, cnt1, tc1, zero1, exp1, etc1, (exp1 == 0));
      end
      n_checks++;
      if (cnt2 !== N2'(exp2) || tc2 !== etc2 || zero2 !== (exp2 == 0)) begin
        n_fail++;
        $display("FAIL random2[%0d]: counter=%0d tc=%b zero=%b, required %0d %b %b",
                 i, cnt2, tc2, zero2, exp2, etc2, (exp2 == 0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
`ifndef UDC_SATURATE_EN
    test_up_wrap();
    test_down_wrap();
`endif
    test_load_clamp();
    test_reversal();
`ifndef UDC_SATURATE_EN
    test_param_variant();
`else
    test_saturate();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
